dual_rail_fifo_bridge: RTL

DUAL_RAIL_FIFO_BRIDGE -- requirements
Module: dual_rail_fifo_bridge

---
 rtl/dual_rail_fifo_bridge.sv | 92 +++++++++
 1 files changed

// File: rtl/dual_rail_fifo_bridge.sv
// dual_rail_fifo_bridge: 4-phase dual-rail receiver feeding a first-word fall-through FIFO
module dual_rail_fifo_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*WIDTH-1:0]       data_in,
  output logic                     ack_ant,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {INIT, IDLE, WAIT_NULL} state_t;
  state_t state;
  logic [WIDTH-1:0] t_rail, f_rail;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SYNC_STAGES-1:0] c_sync, n_sync, i_sync;
  logic complete, is_null, illegal, s_complete, s_null, s_illegal, full, pop, wr;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rail
    assign t_rail[i] = data_in[2*i+1];
    assign f_rail[i] = data_in[2*i];
  end
  assign complete   = &(t_rail ^ f_rail);
  assign is_null    = ~|data_in;
  assign illegal    = |(t_rail & f_rail);
  assign s_complete = c_sync[SYNC_STAGES-1];
  assign s_null     = n_sync[SYNC_STAGES-1];
  assign s_illegal  = i_sync[SYNC_STAGES-1];
  assign full       = count == CW'(DEPTH);
  assign out_valid  = count != '0;
  assign pop        = out_valid & out_ready;
  assign wr         = (state == IDLE) & s_complete & ~full;
  assign out_data   = mem[rd_ptr];
  // bring the asynchronous rail detects into the clock domain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_sync <= '0;
      n_sync <= '0;
      i_sync <= '0;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], complete};
      n_sync <= {n_sync[SYNC_STAGES-2:0], is_null};
      i_sync <= {i_sync[SYNC_STAGES-2:0], illegal};
    end
  // handshake sequencer; INIT waits for a null so a word held across reset is not recaptured
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= INIT;
      ack_ant <= 1'b0;
    end else begin
      case (state)
        INIT:      if (s_null) state <= IDLE;
        IDLE:      if (wr) begin
                     state   <= WAIT_NULL;
                     ack_ant <= 1'b1;
                   end
        WAIT_NULL: if (s_null) begin
                     state   <= IDLE;
                     ack_ant <= 1'b0;
                   end
        default:   begin
                     state   <= INIT;
                     ack_ant <= 1'b0;
                   end
      endcase
    end
  // pointers and occupancy; full is judged on the pre-edge count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  // storage captures the true rails of the held word
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= t_rail;
  // sticky protocol-violation flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_illegal <= 1'b0;
    else if (s_illegal) err_illegal <= 1'b1;
endmodule
